// File: rtl/vga_capture.sv
// vga_capture: grabs one VGA frame from the pixel stream into word RAM.
// Optional CRC-16-CCITT over written pixels when VGA_CAPTURE_CRC_EN is defined.
module vga_capture #(
    parameter int          H_ACTIVE        = 640,
    parameter int          V_ACTIVE        = 480,
    parameter bit          SYNC_ACTIVE_LOW = 1'b1,
    parameter logic [31:0] BASE_ADDR       = 32'h0
) (
    input  logic        clock_25,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  red,
    input  logic [7:0]  green,
    input  logic [7:0]  blue,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        n_blank,
    output logic [31:0] address,
    output logic [31:0] wd,
    output logic        we,
    output logic        busy,
    output logic        done,
    output logic        line_err,
    output logic        frame_err,
    output logic [15:0] crc
);
    localparam logic [31:0] HA = H_ACTIVE;
    localparam logic [31:0] VA = V_ACTIVE;

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
    state_t state;

    logic        start_s, hs_s, vs_s, nb_s, vs_p, nb_p;
    logic [23:0] pix_s;

    // sync levels are stored as "asserted" regardless of pin polarity
    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) begin
            start_s <= 1'b0;
            hs_s    <= 1'b0;
            vs_s    <= 1'b0;
            nb_s    <= 1'b0;
            vs_p    <= 1'b0;
            nb_p    <= 1'b0;
            pix_s   <= 24'h0;
        end else begin
            start_s <= start;
            hs_s    <= hsync ^ SYNC_ACTIVE_LOW;
            vs_s    <= vsync ^ SYNC_ACTIVE_LOW;
            nb_s    <= n_blank;
            vs_p    <= vs_s;
            nb_p    <= nb_s;
            pix_s   <= {red, green, blue};
        end
    end

    logic vs_edge, l_start, l_end;
    assign vs_edge = vs_s & ~vs_p;
    assign l_start = nb_s & ~nb_p;
    assign l_end   = ~nb_s & nb_p;

    logic [31:0] x, y, row;
    logic        x_over, y_over, first, hs_seen;
    logic [31:0] y_nx;
    logic        y_over_nx, wr, arm;

    assign y_nx      = (l_end && y < VA) ? y + 32'd1 : y;
    assign y_over_nx = y_over | (l_end && y == VA);
    assign wr  = (state == CAPTURE) && nb_s && (x < HA) && (y < VA);
    assign arm = (state == IDLE) && start_s;

    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            address   <= 32'h0;
            wd        <= 32'h0;
            we        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            line_err  <= 1'b0;
            frame_err <= 1'b0;
            x         <= 32'h0;
            y         <= 32'h0;
            row       <= 32'h0;
            x_over    <= 1'b0;
            y_over    <= 1'b0;
            first     <= 1'b0;
            hs_seen   <= 1'b0;
        end else begin
            we   <= 1'b0;
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_s) begin
                        state     <= ARMED;
                        busy      <= 1'b1;
                        line_err  <= 1'b0;
                        frame_err <= 1'b0;
                        x         <= 32'h0;
                        y         <= 32'h0;
                    end
                end
                ARMED: begin
                    if (vs_edge) begin
                        state   <= CAPTURE;
                        x       <= 32'h0;
                        y       <= 32'h0;
                        row     <= BASE_ADDR;
                        x_over  <= 1'b0;
                        y_over  <= 1'b0;
                        first   <= 1'b1;
                        hs_seen <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (nb_s) begin
                        if (x < HA) begin
                            if (y < VA) begin
                                we      <= 1'b1;
                                address <= row + x;
                                wd      <= {8'h00, pix_s};
                            end
                            x <= x + 32'd1;
                        end else begin
                            x_over <= 1'b1;
                        end
                    end
                    hs_seen <= l_end ? hs_s : (hs_seen | hs_s);
                    if (l_start) begin
                        if (!first && !(hs_seen | hs_s))
                            line_err <= 1'b1;
                        first <= 1'b0;
                    end
                    if (l_end) begin
                        if (x != HA || x_over)
                            line_err <= 1'b1;
                        x      <= 32'h0;
                        x_over <= 1'b0;
                        y      <= y_nx;
                        y_over <= y_over_nx;
                        row    <= row + HA;
                    end
                    // line end above is folded in before the frame check
                    if (vs_edge) begin
                        if (y_nx != VA || y_over_nx)
                            frame_err <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef VGA_CAPTURE_CRC_EN
    function automatic logic [15:0] crc_step(input logic [15:0] c,
                                             input logic [23:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 23; i >= 0; i--)
            r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0);
        return r;
    endfunction

    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset)
            crc <= 16'h0;
        else if (arm)
            crc <= 16'hFFFF;
        else if (wr)
            crc <= crc_step(crc, pix_s);
    end
`else
    logic unused_crc;
    assign unused_crc = wr ^ arm;
    assign crc = 16'h0;
`endif
endmodule

// File: tb/tb_vga_capture.sv
// Testbench for vga_capture: 8x4 frames from a table of line scenarios,
// plus directed latency, start/vsync collision and mid-frame reset sequences.
module tb_vga_capture;
    logic        clk = 1'b0;
    logic        reset, start, hsync, vsync, n_blank;
    logic [7:0]  red, green, blue;
    logic [31:0] address, wd;
    logic        we, busy, done, line_err, frame_err;
    logic [15:0] crc;

    int errors = 0;
    int checks = 0;
    int wcount = 0;
    int dcount = 0;
    logic [63:0] q[$];

    vga_capture #(.H_ACTIVE(8), .V_ACTIVE(4)) dut (
        .clock_25(clk), .reset(reset), .start(start),
        .red(red), .green(green), .blue(blue),
        .hsync(hsync), .vsync(vsync), .n_blank(n_blank),
        .address(address), .wd(wd), .we(we), .busy(busy), .done(done),
        .line_err(line_err), .frame_err(frame_err), .crc(crc)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, exp);
        end
    endtask

    // scoreboard: every write must match the next expected pixel
    always @(negedge clk) begin
        if (!reset && we) begin
            wcount++;
            if (q.size() == 0) begin
                chk("wr_unexpected", address, 32'hFFFF_FFFF);
            end else begin
                logic [63:0] e;
                e = q.pop_front();
                chk("wr_addr", address, e[63:32]);
                chk("wr_data", wd, e[31:0]);
            end
        end
        if (!reset && done) begin
            dcount++;
            chk("busy_at_done", {31'h0, busy}, 32'h0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vs_pulse();
        vsync = 1'b0;
        tick(); tick();
        vsync = 1'b1;
        tick(); tick();
    endtask

    task automatic pix(int x, int y, bit push, bit zero);
        n_blank = 1'b1;
        red   = zero ? 8'h0 : 8'(x);
        green = zero ? 8'h0 : 8'(y);
        blue  = zero ? 8'h0 : 8'h55;
        if (push && x < 8 && y < 4)
            q.push_back({32'(y * 8 + x), 8'h00, red, green, blue});
    endtask

    task automatic line(int len, bit hs, int y, bit push, bit zero);
        if (hs) hsync = 1'b0;
        tick(); tick();
        hsync = 1'b1;
        tick();
        for (int x = 0; x < len; x++) begin
            pix(x, y, push, zero);
            tick();
        end
        n_blank = 1'b0;
        red = 8'h0; green = 8'h0; blue = 8'h0;
        tick(); tick();
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20 && dcount == 0; i++) tick();
        tick(); tick();
    endtask

    function automatic logic [15:0] crc_zero(int nbits);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < nbits; i++)
            c = c[15] ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
        return c;
    endfunction

    typedef struct {
        string name;
        int    lines;
        int    short_y;
        int    short_len;
        int    nohs_y;
        int    exp_wr;
        bit    exp_le;
        bit    exp_fe;
    } vec_t;

    vec_t vecs[6];

    task automatic run_frame(vec_t v, bit zero);
        q.delete();
        wcount = 0;
        dcount = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        vs_pulse();
        for (int l = 0; l < v.lines; l++)
            line((l == v.short_y) ? v.short_len : 8, l != v.nohs_y, l, 1'b1, zero);
        vs_pulse();
        wait_done();
        chk({v.name, "_writes"}, wcount, v.exp_wr);
        chk({v.name, "_done"}, dcount, 1);
        chk({v.name, "_line_err"}, {31'h0, line_err}, {31'h0, v.exp_le});
        chk({v.name, "_frame_err"}, {31'h0, frame_err}, {31'h0, v.exp_fe});
        chk({v.name, "_left"}, q.size(), 0);
        chk({v.name, "_busy"}, {31'h0, busy}, 32'h0);
`ifdef VGA_CAPTURE_CRC_EN
        if (zero) chk({v.name, "_crc"}, {16'h0, crc}, {16'h0, crc_zero(v.exp_wr * 24)});
`else
        chk({v.name, "_crc"}, {16'h0, crc}, 32'h0);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{"nominal", 4, -1, 8, -1, 32, 1'b0, 1'b0};
        vecs[1] = '{"short",   4,  2, 7, -1, 31, 1'b1, 1'b0};
        vecs[2] = '{"extra",   5, -1, 8, -1, 32, 1'b0, 1'b1};
        vecs[3] = '{"few",     3, -1, 8, -1, 24, 1'b0, 1'b1};
        vecs[4] = '{"long",    4,  1, 9, -1, 32, 1'b1, 1'b0};
        vecs[5] = '{"nohs",    4, -1, 8,  2, 32, 1'b1, 1'b0};

        reset = 1'b1; start = 1'b0; hsync = 1'b1; vsync = 1'b1;
        n_blank = 1'b0; red = 8'h0; green = 8'h0; blue = 8'h0;
        tick(); tick();
        chk("rst_address", address, 32'h0);
        chk("rst_wd", wd, 32'h0);
        chk("rst_we", {31'h0, we}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_line_err", {31'h0, line_err}, 32'h0);
        chk("rst_frame_err", {31'h0, frame_err}, 32'h0);
        chk("rst_crc", {16'h0, crc}, 32'h0);
        reset = 1'b0;
        tick(); tick();

        foreach (vecs[i]) begin
            run_frame(vecs[i], 1'b0);
            tick(); tick();
        end
`ifdef VGA_CAPTURE_CRC_EN
        run_frame(vecs[0], 1'b1);
`endif

        // latency and done/busy timing
        q.delete(); wcount = 0; dcount = 0;
        start = 1'b1; tick(); start = 1'b0; tick(); tick();
        vs_pulse();
        hsync = 1'b0; tick(); tick(); hsync = 1'b1; tick();
        pix(0, 0, 1'b1, 1'b0);
        tick();
        chk("lat_we_k", {31'h0, we}, 32'h0);
        pix(1, 0, 1'b1, 1'b0);
        tick();
        chk("lat_we_k1", {31'h0, we}, 32'h1);
        chk("lat_addr", address, 32'h0);
        chk("lat_wd", wd, 32'h0000_0055);
        for (int x = 2; x < 8; x++) begin
            pix(x, 0, 1'b1, 1'b0);
            tick();
        end
        n_blank = 1'b0; tick(); tick();
        for (int l = 1; l < 4; l++) line(8, 1'b1, l, 1'b1, 1'b0);
        vsync = 1'b0;
        tick();
        chk("done_k", {31'h0, done}, 32'h0);
        tick();
        chk("done_k1", {31'h0, done}, 32'h0);
        chk("busy_k1", {31'h0, busy}, 32'h1);
        tick();
        chk("done_k2", {31'h0, done}, 32'h1);
        chk("busy_k2", {31'h0, busy}, 32'h0);
        tick();
        chk("done_k3", {31'h0, done}, 32'h0);
        vsync = 1'b1; tick(); tick();
        chk("lat_writes", wcount, 32);

        // start and vsync edge together: the edge must not begin capture
        q.delete(); wcount = 0; dcount = 0;
        start = 1'b1; vsync = 1'b0; tick();
        start = 1'b0; tick();
        vsync = 1'b1; tick(); tick();
        chk("coll_armed", {31'h0, busy}, 32'h1);
        line(8, 1'b1, 0, 1'b0, 1'b0);
        chk("coll_nowrite", wcount, 0);
        vs_pulse();
        for (int l = 0; l < 4; l++) line(8, 1'b1, l, 1'b1, 1'b0);
        vs_pulse();
        wait_done();
        chk("coll_writes", wcount, 32);
        chk("coll_done", dcount, 1);
        chk("coll_errs", {30'h0, line_err, frame_err}, 32'h0);

        // reset after 10 writes, then a clean capture
        q.delete(); wcount = 0; dcount = 0;
        start = 1'b1; tick(); start = 1'b0; tick(); tick();
        vs_pulse();
        line(7, 1'b1, 0, 1'b1, 1'b0);
        hsync = 1'b0; tick(); tick(); hsync = 1'b1; tick();
        for (int x = 0; x < 5; x++) begin
            pix(x, 1, 1'b1, 1'b0);
            tick();
        end
        chk("pre_rst_writes", wcount, 10);
        chk("pre_rst_le", {31'h0, line_err}, 32'h1);
        chk("pre_rst_we", {31'h0, we}, 32'h1);
        reset = 1'b1;
        #1;
        chk("rst_mid_we", {31'h0, we}, 32'h0);
        chk("rst_mid_busy", {31'h0, busy}, 32'h0);
        chk("rst_mid_flags", {30'h0, line_err, frame_err}, 32'h0);
        n_blank = 1'b0;
        tick();
        reset = 1'b0;
        q.delete();
        tick(); tick();
        run_frame(vecs[0], 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
